ddr3_traffic_generator: RTL and testbench
=========================================

DDR3_TRAFFIC_GENERATOR -- requirements
Module: ddr3_traffic_generator

Interface
REQ-001 SHALL have parameter ADDRESS_BITWIDTH, default 15, row/column address width.
REQ-002 SHALL have parameter BANK_ADDRESS_BITWIDTH, default 3, bank address width.
REQ-003 SHALL have parameter DQ_BITWIDTH, default 16, user data width; legal values 8 and 16.
REQ-004 SHALL have parameter NUM_WORDS, default 256, words per test pass; legal range 1 to 2**(BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH).
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum cycles without read data in READ phase.
REQ-006 Ports (name, direction, width, meaning):
clk  in  1  single clock; all logic on rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  one-cycle pulse; begins a test pass when idle.
mode  in  2  pattern: 0 incrementing, 1 walking-one, 2 LFSR, 3 checkerboard.
seed  in  DQ_BITWIDTH  pattern seed, sampled at start.
base_address  in  BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH  first word address, sampled at start.
cmd_ready  in  1  controller accepts the command presented this cycle.
write_enable  out  1  write command valid.
read_enable  out  1  read command valid.
i_user_data_address  out  BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH  command address.
i_user_data  out  DQ_BITWIDTH  write data.
o_user_data  in  DQ_BITWIDTH  read data from controller.
o_user_data_valid  in  1  o_user_data valid this cycle.
busy  out  1  test pass in progress.
done  out  1  test pass finished; held until next start.
pass  out  1  high with done when error_count is 0 and no timeout.
timeout  out  1  read-data timeout occurred.
error_count  out  16  mismatches, saturating at 16'hFFFF.
first_error_address  out  BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH  address of first mismatch.

Function
REQ-007 States: IDLE, WRITE, READ, DONE.
REQ-008 IDLE: on start, latch mode/seed/base_address, clear error_count, timeout, first_error_address, counters; next cycle WRITE.
REQ-009 start in WRITE or READ SHALL be ignored; start in DONE behaves as in IDLE.
REQ-010 WRITE: write_enable=1, address=base_address+wr_index (modulo 2**address width, wraps), data=pattern(wr_index); wr_index advances only on cycle with cmd_ready=1.
REQ-011 Command outputs SHALL stay stable while enable high and cmd_ready low.
REQ-012 After write with wr_index=NUM_WORDS-1 accepted, next state READ; write_enable and read_enable never high together.
REQ-013 READ: read_enable=1 with address=base_address+rd_index until NUM_WORDS reads accepted, then read_enable=0.
REQ-014 Each o_user_data_valid in READ SHALL compare o_user_data to pattern(chk_index) and increment chk_index; in-order return assumed by contract with controller.
REQ-015 Mismatch: error_count+1 (saturating); if first mismatch, capture base_address+chk_index.
REQ-016 o_user_data_valid outside READ SHALL be ignored.
REQ-017 Timeout counter resets on every o_user_data_valid; reaching TIMEOUT_CYCLES in READ sets timeout and enters DONE.
REQ-018 READ ends when chk_index reaches NUM_WORDS (that compare included); next state DONE.
REQ-019 DONE: done=1, busy=0, pass=(error_count==0 && !timeout); enables 0.
REQ-020 busy=1 exactly in WRITE and READ.
REQ-021 Patterns, index n: mode 0 seed+n truncated to DQ_BITWIDTH; mode 1 1<<(n mod DQ_BITWIDTH); mode 2 Galois LFSR stepped once per word from seed (seed 0 replaced by 1), taps 16'hB400 for 16 bit, 8'hB8 for 8 bit; mode 3 seed for even n, ~seed for odd n.
REQ-022 Write and check generators SHALL be independent so LFSR sequence restarts from seed for READ.

Reset
REQ-023 reset asserted SHALL immediately force IDLE; write_enable, read_enable, busy, done, pass, timeout = 0; error_count, first_error_address, i_user_data_address, i_user_data = 0; applies mid-pass.

Verification
REQ-024 NUM_WORDS=4, mode 0, seed 16'h0010, base 0, cmd_ready=1, loopback memory -> writes 0x10..0x13 to addr 0..3, then 4 reads; done=1, pass=1, error_count=0.
REQ-025 cmd_ready toggled 1,0,0,1 during WRITE -> address/data held while stalled; exactly NUM_WORDS writes accepted.
REQ-026 mode 1, memory corrupts word at address 2 -> error_count=1, first_error_address=base+2, pass=0.
REQ-027 base_address all-ones, NUM_WORDS=2 -> addresses all-ones then 0.
REQ-028 no o_user_data_valid in READ, TIMEOUT_CYCLES=8 -> timeout=1, done=1, pass=0 after 8 cycles.
REQ-029 reset pulse during WRITE -> outputs at reset values same cycle; subsequent start runs full pass normally.

Source files
------------

// File: rtl/ddr3_traffic_generator.sv
// Memory test traffic generator: writes a pattern to a contiguous address range,
// reads it back, and reports mismatches and read-data timeouts.
module ddr3_traffic_generator #(
   parameter int unsigned ADDRESS_BITWIDTH      = 15,
   parameter int unsigned BANK_ADDRESS_BITWIDTH = 3,
   parameter int unsigned DQ_BITWIDTH           = 16,
   parameter int unsigned NUM_WORDS             = 256,
   parameter int unsigned TIMEOUT_CYCLES        = 1024
) (
   input  logic                                              clk,
   input  logic                                              reset,
   input  logic                                              start,
   input  logic [1:0]                                        mode,
   input  logic [DQ_BITWIDTH-1:0]                            seed,
   input  logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] base_address,
   input  logic                                              cmd_ready,
   output logic                                              write_enable,
   output logic                                              read_enable,
   output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] i_user_data_address,
   output logic [DQ_BITWIDTH-1:0]                            i_user_data,
   input  logic [DQ_BITWIDTH-1:0]                            o_user_data,
   input  logic                                              o_user_data_valid,
   output logic                                              busy,
   output logic                                              done,
   output logic                                              pass,
   output logic                                              timeout,
   output logic [15:0]                                       error_count,
   output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] first_error_address
);

   localparam int unsigned AW = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
   localparam int unsigned DW = DQ_BITWIDTH;
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [AW-1:0] LAST = AW'(NUM_WORDS - 1);
   localparam logic [DW-1:0] TAPS = (DW == 16) ? DW'(16'hB400) : DW'(8'hB8);

   typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

   state_t        state_q, state_d;
   logic [1:0]    mode_q, mode_d;
   logic [AW-1:0] base_q, base_d;
   logic [AW-1:0] wr_idx_q, wr_idx_d;
   logic [AW-1:0] rd_idx_q, rd_idx_d;
   logic [AW-1:0] chk_idx_q, chk_idx_d;
   logic [DW-1:0] chk_pat_q, chk_pat_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          we_d, re_d, busy_d, done_d, pass_d, timeout_d;
   logic [AW-1:0] addr_d, fea_d;
   logic [DW-1:0] data_d;
   logic [15:0]   err_d;
   logic          finish;

   // First word of a pattern; LFSR seed 0 would lock up, so it becomes 1.
   function automatic logic [DW-1:0] pat_init(input logic [1:0] m, input logic [DW-1:0] s);
      case (m)
         2'd1:    pat_init = DW'(1);
         2'd2:    pat_init = (s == '0) ? DW'(1) : s;
         default: pat_init = s;
      endcase
   endfunction

   // Pattern word n+1 derived from word n.
   function automatic logic [DW-1:0] pat_next(input logic [1:0] m, input logic [DW-1:0] cur);
      case (m)
         2'd0:    pat_next = cur + DW'(1);
         2'd1:    pat_next = {cur[DW-2:0], cur[DW-1]};
         2'd2:    pat_next = (cur >> 1) ^ (cur[0] ? TAPS : '0);
         default: pat_next = ~cur;
      endcase
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q             <= IDLE;
         mode_q              <= '0;
         base_q              <= '0;
         wr_idx_q            <= '0;
         rd_idx_q            <= '0;
         chk_idx_q           <= '0;
         chk_pat_q           <= '0;
         tmo_q               <= '0;
         write_enable        <= 1'b0;
         read_enable         <= 1'b0;
         i_user_data_address <= '0;
         i_user_data         <= '0;
         busy                <= 1'b0;
         done                <= 1'b0;
         pass                <= 1'b0;
         timeout             <= 1'b0;
         error_count         <= '0;
         first_error_address <= '0;
      end else begin
         state_q             <= state_d;
         mode_q              <= mode_d;
         base_q              <= base_d;
         wr_idx_q            <= wr_idx_d;
         rd_idx_q            <= rd_idx_d;
         chk_idx_q           <= chk_idx_d;
         chk_pat_q           <= chk_pat_d;
         tmo_q               <= tmo_d;
         write_enable        <= we_d;
         read_enable         <= re_d;
         i_user_data_address <= addr_d;
         i_user_data         <= data_d;
         busy                <= busy_d;
         done                <= done_d;
         pass                <= pass_d;
         timeout             <= timeout_d;
         error_count         <= err_d;
         first_error_address <= fea_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      base_d    = base_q;
      wr_idx_d  = wr_idx_q;
      rd_idx_d  = rd_idx_q;
      chk_idx_d = chk_idx_q;
      chk_pat_d = chk_pat_q;
      tmo_d     = tmo_q;
      we_d      = write_enable;
      re_d      = read_enable;
      addr_d    = i_user_data_address;
      data_d    = i_user_data;
      busy_d    = busy;
      done_d    = done;
      pass_d    = pass;
      timeout_d = timeout;
      err_d     = error_count;
      fea_d     = first_error_address;
      finish    = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d   = WRITE;
               mode_d    = mode;
               base_d    = base_address;
               wr_idx_d  = '0;
               rd_idx_d  = '0;
               chk_idx_d = '0;
               chk_pat_d = pat_init(mode, seed);
               tmo_d     = '0;
               we_d      = 1'b1;
               re_d      = 1'b0;
               addr_d    = base_address;
               data_d    = pat_init(mode, seed);
               busy_d    = 1'b1;
               done_d    = 1'b0;
               pass_d    = 1'b0;
               timeout_d = 1'b0;
               err_d     = '0;
               fea_d     = '0;
            end
         end
         WRITE: begin
            if (cmd_ready) begin
               if (wr_idx_q == LAST) begin
                  state_d = READ;
                  we_d    = 1'b0;
                  re_d    = 1'b1;
                  addr_d  = base_q;
               end else begin
                  wr_idx_d = wr_idx_q + AW'(1);
                  addr_d   = i_user_data_address + AW'(1);
                  data_d   = pat_next(mode_q, i_user_data);
               end
            end
         end
         READ: begin
            // Command issue and data checking run independently in this phase.
            if (read_enable && cmd_ready) begin
               if (rd_idx_q == LAST) begin
                  re_d = 1'b0;
               end else begin
                  rd_idx_d = rd_idx_q + AW'(1);
                  addr_d   = i_user_data_address + AW'(1);
               end
            end
            if (o_user_data_valid) begin
               tmo_d = '0;
               if (o_user_data != chk_pat_q) begin
                  if (error_count != 16'hFFFF) err_d = error_count + 16'd1;
                  if (error_count == '0) fea_d = base_q + chk_idx_q;
               end
               chk_idx_d = chk_idx_q + AW'(1);
               chk_pat_d = pat_next(mode_q, chk_pat_q);
               if (chk_idx_q == LAST) finish = 1'b1;
            end else begin
               tmo_d = tmo_q + TW'(1);
               if (tmo_d == TW'(TIMEOUT_CYCLES)) begin
                  timeout_d = 1'b1;
                  finish    = 1'b1;
               end
            end
            if (finish) begin
               state_d = DONE;
               we_d    = 1'b0;
               re_d    = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_d == '0) && !timeout_d;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ddr3_traffic_generator.sv
// Randomized bench for ddr3_traffic_generator: loopback memory with optional
// corruption, transaction-level reference model, and per-cycle output checks.
module tb_ddr3_traffic_generator;

   localparam int AW = 4;
   localparam int DW = 16;
   localparam int N  = 4;
   localparam int T  = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [1:0]    mode = '0;
   logic [DW-1:0] seed = '0;
   logic [AW-1:0] base_address = '0;
   logic          cmd_ready = 1'b0;
   logic [DW-1:0] o_user_data = '0;
   logic          o_user_data_valid = 1'b0;
   logic          write_enable, read_enable, busy, done, pass, timeout;
   logic [AW-1:0] i_user_data_address, first_error_address;
   logic [DW-1:0] i_user_data;
   logic [15:0]   error_count;

   always #5 clk = ~clk;

   ddr3_traffic_generator #(
      .ADDRESS_BITWIDTH(3), .BANK_ADDRESS_BITWIDTH(1), .DQ_BITWIDTH(DW),
      .NUM_WORDS(N), .TIMEOUT_CYCLES(T)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .seed(seed),
      .base_address(base_address), .cmd_ready(cmd_ready),
      .write_enable(write_enable), .read_enable(read_enable),
      .i_user_data_address(i_user_data_address), .i_user_data(i_user_data),
      .o_user_data(o_user_data), .o_user_data_valid(o_user_data_valid),
      .busy(busy), .done(done), .pass(pass), .timeout(timeout),
      .error_count(error_count), .first_error_address(first_error_address)
   );

   int total = 0;
   int bad = 0;

   // Reference model: phase 0 idle, 1 writing, 2 reading, 3 finished.
   int            ph, wn, rn, ck, gap, cyc;
   logic [15:0]   m_err;
   logic [AW-1:0] m_fea, m_base;
   logic [1:0]    m_mode;
   logic [15:0]   m_seed;
   logic          m_tout;
   logic [15:0]   mem [16];
   logic [AW-1:0] wr_log [$];
   typedef struct {logic [15:0] d; int due;} ret_t;
   ret_t          rq [$];
   int            corrupt, rmode, sidx, lowrun;
   bit            mute;
   logic [15:0]   p_data;
   logic [3:0]    scr = 4'b1001;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Pattern word n straight from the definition of each mode.
   function automatic logic [15:0] pat(input int n, input logic [1:0] m, input logic [15:0] s);
      logic [15:0] x;
      case (m)
         2'd0: return s + 16'(n);
         2'd1: return 16'(1) << (n % 16);
         2'd2: begin
            x = (s == 16'h0) ? 16'h1 : s;
            for (int i = 0; i < n; i++) x = {1'b0, x[15:1]} ^ (x[0] ? 16'hB400 : 16'h0);
            return x;
         end
         default: return (n % 2 == 1) ? ~s : s;
      endcase
   endfunction

   task automatic model_reset();
      ph = 0; wn = 0; rn = 0; ck = 0; gap = 0;
      m_err = '0; m_fea = '0; m_tout = 1'b0;
      rq.delete();
      p_data = '0;
      start = 1'b0;
      o_user_data_valid = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_we"}, 32'(write_enable), 32'h0);
      check({tag, "_re"}, 32'(read_enable), 32'h0);
      check({tag, "_busy"}, 32'(busy), 32'h0);
      check({tag, "_done"}, 32'(done), 32'h0);
      check({tag, "_pass"}, 32'(pass), 32'h0);
      check({tag, "_timeout"}, 32'(timeout), 32'h0);
      check({tag, "_err"}, 32'(error_count), 32'h0);
      check({tag, "_fea"}, 32'(first_error_address), 32'h0);
      check({tag, "_addr"}, 32'(i_user_data_address), 32'h0);
      check({tag, "_data"}, 32'(i_user_data), 32'h0);
   endtask

   // One clock: apply model to the inputs seen at the edge, compare, drive next inputs.
   task automatic cycle();
      logic [AW-1:0] a;
      ret_t r;
      @(posedge clk);
      #1;
      cyc++;
      if (start && (ph == 0 || ph == 3)) begin
         m_mode = mode; m_seed = seed; m_base = base_address;
         ph = 1; wn = 0; rn = 0; ck = 0; gap = 0;
         m_err = '0; m_fea = '0; m_tout = 1'b0;
         wr_log.delete(); rq.delete();
      end else if (ph == 1) begin
         if (cmd_ready) begin
            a = AW'(m_base + AW'(wn));
            mem[a] = p_data;
            wr_log.push_back(a);
            wn++;
            if (wn == N) ph = 2;
         end
      end else if (ph == 2) begin
         if (rn < N && cmd_ready) begin
            a = AW'(m_base + AW'(rn));
            r.d = mem[a] ^ ((int'(a) == corrupt) ? 16'h0100 : 16'h0000);
            r.due = cyc + 1 + int'($urandom % 2);
            rq.push_back(r);
            rn++;
         end
         if (o_user_data_valid) begin
            if (o_user_data !== pat(ck, m_mode, m_seed)) begin
               if (m_err == 16'h0) m_fea = AW'(m_base + AW'(ck));
               if (m_err != 16'hFFFF) m_err++;
            end
            ck++;
            gap = 0;
            if (ck == N) ph = 3;
         end else begin
            gap++;
            if (gap == T) begin
               m_tout = 1'b1;
               ph = 3;
            end
         end
      end

      check("write_enable", 32'(write_enable), 32'(ph == 1));
      check("read_enable", 32'(read_enable), 32'(ph == 2 && rn < N));
      check("busy", 32'(busy), 32'(ph == 1 || ph == 2));
      check("done", 32'(done), 32'(ph == 3));
      check("pass", 32'(pass), 32'(ph == 3 && m_err == 16'h0 && !m_tout));
      check("timeout", 32'(timeout), 32'(m_tout));
      check("error_count", 32'(error_count), 32'(m_err));
      check("first_error_address", 32'(first_error_address), 32'(m_fea));
      if (ph == 1) begin
         check("write_address", 32'(i_user_data_address), 32'(AW'(m_base + AW'(wn))));
         check("write_data", 32'(i_user_data), 32'(pat(wn, m_mode, m_seed)));
      end
      if (ph == 2 && rn < N)
         check("read_address", 32'(i_user_data_address), 32'(AW'(m_base + AW'(rn))));
      p_data = i_user_data;

      // Next inputs; start and config are scrambled mid-pass to prove they are ignored.
      start = 1'b0;
      if (ph == 1 || ph == 2) begin
         start = ($urandom % 8 == 0);
         mode = 2'($urandom);
         seed = 16'($urandom);
         base_address = AW'($urandom);
      end
      if (rmode == 2) cmd_ready = 1'b1;
      else if (rmode == 1 && ph == 1) begin
         cmd_ready = scr[3 - (sidx % 4)];
         sidx++;
      end else if (rmode == 1) cmd_ready = 1'b1;
      else begin
         cmd_ready = ($urandom % 4 != 0);
         if (!cmd_ready && lowrun >= 2) cmd_ready = 1'b1;
      end
      lowrun = cmd_ready ? 0 : lowrun + 1;
      o_user_data_valid = 1'b0;
      o_user_data = 16'($urandom);
      if (ph == 2) begin
         if (!mute && rq.size() > 0 && rq[0].due <= cyc) begin
            o_user_data_valid = 1'b1;
            o_user_data = rq[0].d;
            void'(rq.pop_front());
         end
      end else if ($urandom % 5 == 0) begin
         o_user_data_valid = 1'b1;
      end
   endtask

   task automatic run_pass(input logic [1:0] md, input logic [15:0] sd, input logic [AW-1:0] b,
                           input int cor, input bit mu, input int rm, input int rst_at);
      mode = md; seed = sd; base_address = b;
      corrupt = cor; mute = mu; rmode = rm; sidx = 0;
      start = 1'b1;
      for (int i = 0; i < 300; i++) begin
         cycle();
         if (i == rst_at) begin
            #1 reset = 1'b1;
            #1 check_reset_values("midpass_reset");
            @(negedge clk) reset = 1'b0;
            model_reset();
            return;
         end
         if (ph == 3) return;
      end
      total++;
      bad++;
      $display("FAIL pass_bound: phase=%0d required 3 within 300 cycles", ph);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = '0;
      cyc = 0; lowrun = 0; rmode = 2; corrupt = -1; mute = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 check_reset_values("reset");
      @(negedge clk) reset = 1'b0;

      check("pat_incr", 32'(pat(2, 2'd0, 16'h0010)), 32'h0012);
      check("pat_walk", 32'(pat(3, 2'd1, 16'h0000)), 32'h0008);
      check("pat_lfsr", 32'(pat(1, 2'd2, 16'h0001)), 32'hB400);
      check("pat_lfsr_seed0", 32'(pat(1, 2'd2, 16'h0000)), 32'hB400);
      check("pat_checker", 32'(pat(1, 2'd3, 16'hA5A5)), 32'h5A5A);

      // Basic loopback, incrementing pattern.
      run_pass(2'd0, 16'h0010, 4'h0, -1, 1'b0, 2, -1);
      repeat (2) cycle();
      check("basic_done", 32'(done), 32'h1);
      check("basic_pass", 32'(pass), 32'h1);
      check("basic_err", 32'(error_count), 32'h0);
      for (int i = 0; i < 4; i++) begin
         check("basic_mem", 32'(mem[i]), 32'h10 + 32'(i));
         check("basic_addr", 32'(wr_log[i]), 32'(i));
      end

      // Stalled writes with ready 1,0,0,1.
      run_pass(2'd3, 16'hA5A5, 4'h5, -1, 1'b0, 1, -1);
      check("stall_write_count", 32'(wr_log.size()), 32'(N));
      check("stall_pass", 32'(pass), 32'h1);

      // Corrupted word at base+2.
      run_pass(2'd1, 16'h0000, 4'h3, 5, 1'b0, 0, -1);
      cycle();
      check("corrupt_err", 32'(error_count), 32'h1);
      check("corrupt_fea", 32'(first_error_address), 32'h5);
      check("corrupt_pass", 32'(pass), 32'h0);

      // Address wrap from all-ones.
      run_pass(2'd2, 16'h0000, 4'hF, -1, 1'b0, 0, -1);
      check("wrap_addr0", 32'(wr_log[0]), 32'hF);
      check("wrap_addr1", 32'(wr_log[1]), 32'h0);

      // No read data: timeout.
      run_pass(2'd0, 16'h1234, 4'h2, -1, 1'b1, 0, -1);
      cycle();
      check("tmo_timeout", 32'(timeout), 32'h1);
      check("tmo_done", 32'(done), 32'h1);
      check("tmo_pass", 32'(pass), 32'h0);

      // Reset during WRITE, then a full pass.
      run_pass(2'd2, 16'hBEEF, 4'h7, -1, 1'b0, 1, 2);
      repeat (2) cycle();
      run_pass(2'd2, 16'hBEEF, 4'h7, -1, 1'b0, 0, -1);
      check("after_reset_pass", 32'(pass), 32'h1);

      for (int k = 0; k < 8; k++) begin
         run_pass(2'($urandom), 16'($urandom), AW'($urandom), int'($urandom_range(0, 20)),
                  1'b0, int'($urandom % 3), -1);
         repeat (int'($urandom % 3)) cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
